game_flow_ctrl: RTL and testbench
=================================

// Module: game_flow_ctrl
// PURPOSE
//  Consumer of the power-up 'start' level from the start-delay block; owns game sequencing.
//  Arms on start, serves the ball, runs play, counts lives on lose, holds win/lose screens, restarts.
//  Drives ball_logic (run, ball_reset) and collision_logic block memory (game_reset); frame-paced by vsync.
// PARAMETERS
//  SERVE_FRAMES  60   frames ball is held at serve position before play (1..255)
//  END_FRAMES    180  frames WON/LOST screen is held before automatic restart (1..255)
//  LIVES         3    lives per game (1..7)
// PORTS
//  pxl_clk      in   1  25 MHz pixel clock; the only clock
//  reset        in   1  asynchronous, active-high reset
//  start        in   1  level from start-delay block; 1 = monitor synced, game may run
//  vsync        in   1  VGA vsync, active-low, synchronous to pxl_clk
//  win          in   1  level from collision_logic: all blocks cleared
//  lose         in   1  level from collision_logic: ball passed paddle
//  run          out  1  1 = ball_logic may move ball
//  ball_reset   out  1  1-cycle pulse: recentre ball
//  game_reset   out  1  1-cycle pulse: restore all blocks
//  lives_left   out  3  remaining lives, for display
//  game_state   out  3  encoded state, for display_logic
// BEHAVIOUR
//  Clock/reset: one clock; reset is asynchronous and active-high.
//  Reset values: run=0, ball_reset=0, game_reset=0, lives_left=LIVES, game_state=IDLE, counters=0.
//  Frame tick: registered vsync; tick = 1-cycle pulse on its 1->0 transition (1 cycle after pin edge).
//  States (game_state code): IDLE=0 SERVE=1 PLAY=2 MISS=3 WON=4 LOST=5 RESTART=6.
//   IDLE:    run=0; start=1 -> RESTART.
//   RESTART: game_reset=1 and ball_reset=1 for exactly this one cycle; lives_left<=LIVES -> SERVE.
//   SERVE:   run=0; frame_cnt counts ticks; at SERVE_FRAMES-th tick -> PLAY, frame_cnt<=0.
//   PLAY:    run=1 (Moore, from state register); win=1 -> WON (win wins if win&lose same cycle);
//            else lose=1 -> MISS.
//   MISS:    one cycle; lives_left decrements; if lives_left was 1 -> LOST (lives_left=0);
//            else ball_reset=1 this cycle -> SERVE.
//   WON/LOST: run=0; hold; at END_FRAMES-th tick -> RESTART.
//  start=0 seen in any non-IDLE state -> IDLE next cycle, run=0; lives/counters untouched until RESTART.
//  win/lose are levels: sampled only in PLAY; SERVE/MISS/WON/LOST ignore them (no double decrement).
//  frame_cnt: 8-bit, cleared on every state entry, never wraps (exit at limit). Tick in the same cycle as
//   state entry is not counted.
//  Pulses: ball_reset/game_reset registered, never high for >1 consecutive cycle.
//  lives_left saturates at 0; never decremented outside MISS.
//  Reset mid-game: all outputs to reset values immediately (async), resume from IDLE.
// STRUCTURE
//  Shared package/defines.v: state encodings (IDLE..RESTART), GAME_STATE_W=3, LIVES_W=3.
//  Sub-module frame_tick (vsync register + falling-edge pulse); reusable by ball_logic.
//  Top: one state register, next-state case, frame_cnt, lives_left; registered outputs.
// TESTING (SERVE_FRAMES=2, END_FRAMES=3, LIVES=3, short vsync period)
//  1 reset high, start=0, 10 frames -> game_state=0, run=0, lives_left=3, no pulses.
//  2 start 0->1 -> RESTART 1 cycle with game_reset=ball_reset=1; SERVE; run=1 after 2nd tick.
//  3 in PLAY pulse lose 1 cycle -> MISS, lives 3->2, ball_reset pulse, SERVE 2 ticks, PLAY.
//  4 three lose events -> lives_left=0, state LOST, run=0; after 3 ticks RESTART, lives_left=3.
//  5 win and lose high same cycle in PLAY -> WON, lives_left unchanged; lose held in WON ignored.
//  6 start dropped in PLAY -> IDLE next cycle, run=0; async reset mid-SERVE -> outputs reset immediately.

Source files
------------

// File: rtl/game_flow_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// game_flow_ctrl_pkg
//   Shared definitions for the game sequencing logic: state encodings that
//   display_logic decodes, output field widths, and a saturating decrement
//   used for the lives counter.
// ---------------------------------------------------------------------------
package game_flow_ctrl_pkg;

    localparam int GAME_STATE_W = 3;
    localparam int LIVES_W      = 3;
    localparam int FRAME_CNT_W  = 8;

    // Codes are visible on game_state, so values are pinned explicitly.
    typedef enum logic [GAME_STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_SERVE   = 3'd1,
        ST_PLAY    = 3'd2,
        ST_MISS    = 3'd3,
        ST_WON     = 3'd4,
        ST_LOST    = 3'd5,
        ST_RESTART = 3'd6
    } game_state_e;

    // Decrement that sticks at zero.
    function automatic logic [LIVES_W-1:0] sat_dec(input logic [LIVES_W-1:0] val);
        return (val == '0) ? '0 : val - 1'b1;
    endfunction

endpackage

// File: rtl/game_flow_ctrl_frame_tick.sv
// ---------------------------------------------------------------------------
// game_flow_ctrl_frame_tick
//   Turns the active-low VGA vsync into a one-cycle frame tick. vsync is
//   registered twice; tick fires on the falling edge of the first register,
//   i.e. one cycle after the pin edge. Reusable by ball_logic.
// Ports
//   pxl_clk  in  pixel clock
//   reset    in  asynchronous, active-high reset
//   vsync    in  VGA vsync (active-low), synchronous to pxl_clk
//   tick     out one-cycle pulse per frame
// ---------------------------------------------------------------------------
module game_flow_ctrl_frame_tick (
    input  logic pxl_clk,
    input  logic reset,
    input  logic vsync,
    output logic tick
);

    logic vsync_q;
    logic vsync_dly_q;

    // Both stages reset to the idle (high) level so leaving reset never
    // produces a spurious tick.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others regardless of statement order.
    always_ff @(posedge pxl_clk or posedge reset) begin
        if (reset) begin
            vsync_q     <= 1'b1;
            vsync_dly_q <= 1'b1;
        end else begin
            vsync_q     <= vsync;
            vsync_dly_q <= vsync_q;
        end
    end

    assign tick = vsync_dly_q & ~vsync_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// ---------------------------------------------------------------------------
// game_flow_ctrl
//   Owns game sequencing: arms on the start level, serves the ball, runs
//   play, counts lives on each miss, holds the WON/LOST screens and restarts.
//   All timing is paced in frames via the vsync-derived tick.
// Parameters
//   SERVE_FRAMES  frames the ball is held at serve before play (1..255)
//   END_FRAMES    frames the WON/LOST screen is held before restart (1..255)
//   LIVES         lives per game (1..7)
// Ports
//   pxl_clk     in   pixel clock, the only clock
//   reset       in   asynchronous, active-high reset
//   start       in   1 = monitor synced, game may run
//   vsync       in   VGA vsync, active-low
//   win         in   level: all blocks cleared
//   lose        in   level: ball passed paddle
//   run         out  1 = ball_logic may move the ball
//   ball_reset  out  one-cycle pulse: recentre the ball
//   game_reset  out  one-cycle pulse: restore all blocks
//   lives_left  out  remaining lives
//   game_state  out  encoded state for display_logic
// ---------------------------------------------------------------------------
module game_flow_ctrl
    import game_flow_ctrl_pkg::*;
#(
    parameter int SERVE_FRAMES = 60,
    parameter int END_FRAMES   = 180,
    parameter int LIVES        = 3
) (
    input  logic                    pxl_clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    vsync,
    input  logic                    win,
    input  logic                    lose,
    output logic                    run,
    output logic                    ball_reset,
    output logic                    game_reset,
    output logic [LIVES_W-1:0]      lives_left,
    output logic [GAME_STATE_W-1:0] game_state
);

    // Counter values at which the final frame of each hold is reached.
    localparam logic [FRAME_CNT_W-1:0] SERVE_LAST = FRAME_CNT_W'(SERVE_FRAMES - 1);
    localparam logic [FRAME_CNT_W-1:0] END_LAST   = FRAME_CNT_W'(END_FRAMES - 1);
    localparam logic [LIVES_W-1:0]     LIVES_INIT = LIVES_W'(LIVES);

    logic tick;

    game_state_e              state_q,      state_d;
    logic [FRAME_CNT_W-1:0]   frame_cnt_q,  frame_cnt_d;
    logic [LIVES_W-1:0]       lives_q,      lives_d;
    logic                     run_q,        run_d;
    logic                     ball_reset_q, ball_reset_d;
    logic                     game_reset_q, game_reset_d;

    game_flow_ctrl_frame_tick u_frame_tick (
        .pxl_clk (pxl_clk),
        .reset   (reset),
        .vsync   (vsync),
        .tick    (tick)
    );

    // -----------------------------------------------------------------------
    // Next-state, counters and output decode
    // -----------------------------------------------------------------------
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        lives_d     = lives_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RESTART;
            end

            ST_RESTART: begin
                lives_d = LIVES_INIT;
                state_d = ST_SERVE;
            end

            ST_SERVE: begin
                if (tick) begin
                    if (frame_cnt_q == SERVE_LAST) state_d = ST_PLAY;
                    else                           frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end

            ST_PLAY: begin
                // win takes priority when both levels arrive together.
                if (win)       state_d = ST_WON;
                else if (lose) state_d = ST_MISS;
            end

            ST_MISS: begin
                lives_d = sat_dec(lives_q);
                state_d = (lives_q <= LIVES_W'(1)) ? ST_LOST : ST_SERVE;
            end

            ST_WON, ST_LOST: begin
                if (tick) begin
                    if (frame_cnt_q == END_LAST) state_d = ST_RESTART;
                    else                         frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Losing start aborts any active state; lives are left as they are
        // until the next RESTART reloads them.
        if ((state_q != ST_IDLE) && !start) begin
            state_d = ST_IDLE;
            lives_d = lives_q;
        end

        // Each state begins its frame count from zero.
        if (state_d != state_q) frame_cnt_d = '0;

        // Outputs are computed from the next state and registered so they
        // line up cycle-for-cycle with state_q.
        run_d        = (state_d == ST_PLAY);
        game_reset_d = (state_d == ST_RESTART);
        // A miss that still leaves a life recentres the ball during MISS.
        ball_reset_d = (state_d == ST_RESTART) ||
                       ((state_d == ST_MISS) && (lives_q > LIVES_W'(1)));
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge pxl_clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            frame_cnt_q  <= '0;
            lives_q      <= LIVES_INIT;
            run_q        <= 1'b0;
            ball_reset_q <= 1'b0;
            game_reset_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            lives_q      <= lives_d;
            run_q        <= run_d;
            ball_reset_q <= ball_reset_d;
            game_reset_q <= game_reset_d;
        end
    end

    assign run        = run_q;
    assign ball_reset = ball_reset_q;
    assign game_reset = game_reset_q;
    assign lives_left = lives_q;
    assign game_state = state_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_flow_ctrl
//   Directed bench for game_flow_ctrl with SERVE_FRAMES=2, END_FRAMES=3,
//   LIVES=3 and a short vsync pulse per frame.
// ---------------------------------------------------------------------------
module tb_game_flow_ctrl;

    localparam int SF = 2;
    localparam int EF = 3;
    localparam int LV = 3;

    logic       pxl_clk = 1'b0;
    logic       reset;
    logic       start;
    logic       vsync;
    logic       win;
    logic       lose;
    logic       run;
    logic       ball_reset;
    logic       game_reset;
    logic [2:0] lives_left;
    logic [2:0] game_state;

    int errors = 0;
    int checks = 0;

    // Pulse-width monitor and idle pulse counter.
    int br_run = 0, gr_run = 0, br_max = 0, gr_max = 0, pulse_cnt = 0;

    game_flow_ctrl #(
        .SERVE_FRAMES (SF),
        .END_FRAMES   (EF),
        .LIVES        (LV)
    ) dut (
        .pxl_clk    (pxl_clk),
        .reset      (reset),
        .start      (start),
        .vsync      (vsync),
        .win        (win),
        .lose       (lose),
        .run        (run),
        .ball_reset (ball_reset),
        .game_reset (game_reset),
        .lives_left (lives_left),
        .game_state (game_state)
    );

    always #20 pxl_clk = ~pxl_clk;

    always @(negedge pxl_clk) begin
        if (ball_reset) br_run = br_run + 1; else br_run = 0;
        if (game_reset) gr_run = gr_run + 1; else gr_run = 0;
        if (br_run > br_max) br_max = br_run;
        if (gr_run > gr_max) gr_max = gr_run;
        if (ball_reset || game_reset) pulse_cnt = pulse_cnt + 1;
    end

    // One frame: vsync low for one cycle. Returns on the negedge right after
    // the edge that acts on the tick, so any transition is already visible.
    task automatic send_tick();
        @(negedge pxl_clk) vsync = 1'b0;
        @(negedge pxl_clk) vsync = 1'b1;
        @(negedge pxl_clk);
    endtask

    // Single-cycle lose pulse; returns on the negedge where MISS is visible.
    task automatic pulse_lose();
        @(negedge pxl_clk) lose = 1'b1;
        @(negedge pxl_clk) lose = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; vsync = 1'b1; win = 1'b0; lose = 1'b0;
        repeat (3) @(negedge pxl_clk);
        checks++; if (game_state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", game_state); end
        checks++; if (run !== 1'b0)        begin errors++; $display("FAIL reset_run got=%b exp=0", run); end
        checks++; if (lives_left !== 3'd3) begin errors++; $display("FAIL reset_lives got=%0d exp=3", lives_left); end
        checks++; if ({ball_reset, game_reset} !== 2'b00) begin errors++; $display("FAIL reset_pulses got=%b exp=00", {ball_reset, game_reset}); end
        reset = 1'b0;
        pulse_cnt = 0;
        repeat (10) send_tick();
        checks++; if (game_state !== 3'd0) begin errors++; $display("FAIL idle_state got=%0d exp=0", game_state); end
        checks++; if (run !== 1'b0)        begin errors++; $display("FAIL idle_run got=%b exp=0", run); end
        checks++; if (lives_left !== 3'd3) begin errors++; $display("FAIL idle_lives got=%0d exp=3", lives_left); end
        checks++; if (pulse_cnt !== 0)     begin errors++; $display("FAIL idle_pulses got=%0d exp=0", pulse_cnt); end
    endtask

    task automatic test_start_serve();
        @(negedge pxl_clk) start = 1'b1;
        @(negedge pxl_clk);
        checks++; if (game_state !== 3'd6) begin errors++; $display("FAIL restart_state got=%0d exp=6", game_state); end
        checks++; if ({game_reset, ball_reset} !== 2'b11) begin errors++; $display("FAIL restart_pulses got=%b exp=11", {game_reset, ball_reset}); end
        @(negedge pxl_clk);
        checks++; if (game_state !== 3'd1) begin errors++; $display("FAIL serve_state got=%0d exp=1", game_state); end
        checks++; if ({game_reset, ball_reset, run} !== 3'b000) begin errors++; $display("FAIL serve_outs got=%b exp=000", {game_reset, ball_reset, run}); end
        send_tick();
        checks++; if (game_state !== 3'd1 || run !== 1'b0) begin errors++; $display("FAIL serve_tick1 got=%0d/%b exp=1/0", game_state, run); end
        send_tick();
        checks++; if (game_state !== 3'd2 || run !== 1'b1) begin errors++; $display("FAIL serve_tick2 got=%0d/%b exp=2/1", game_state, run); end
    endtask

    task automatic test_miss();
        pulse_lose();
        checks++; if (game_state !== 3'd3) begin errors++; $display("FAIL miss_state got=%0d exp=3", game_state); end
        checks++; if (ball_reset !== 1'b1 || run !== 1'b0) begin errors++; $display("FAIL miss_outs got=%b%b exp=10", ball_reset, run); end
        @(negedge pxl_clk);
        checks++; if (game_state !== 3'd1 || lives_left !== 3'd2) begin errors++; $display("FAIL miss_serve got=%0d/%0d exp=1/2", game_state, lives_left); end
        checks++; if (ball_reset !== 1'b0) begin errors++; $display("FAIL miss_pulse_end got=%b exp=0", ball_reset); end
        send_tick();
        send_tick();
        checks++; if (game_state !== 3'd2 || run !== 1'b1) begin errors++; $display("FAIL miss_replay got=%0d/%b exp=2/1", game_state, run); end
    endtask

    task automatic test_lives_out();
        pulse_lose();
        @(negedge pxl_clk);
        checks++; if (lives_left !== 3'd1) begin errors++; $display("FAIL lives_to_1 got=%0d exp=1", lives_left); end
        send_tick();
        send_tick();
        pulse_lose();
        checks++; if (game_state !== 3'd3 || ball_reset !== 1'b0) begin errors++; $display("FAIL last_miss got=%0d/%b exp=3/0", game_state, ball_reset); end
        @(negedge pxl_clk);
        checks++; if (game_state !== 3'd5 || lives_left !== 3'd0 || run !== 1'b0) begin errors++; $display("FAIL lost got=%0d/%0d/%b exp=5/0/0", game_state, lives_left, run); end
        send_tick();
        send_tick();
        checks++; if (game_state !== 3'd5 || lives_left !== 3'd0) begin errors++; $display("FAIL lost_hold got=%0d/%0d exp=5/0", game_state, lives_left); end
        send_tick();
        checks++; if (game_state !== 3'd6 || game_reset !== 1'b1) begin errors++; $display("FAIL lost_restart got=%0d/%b exp=6/1", game_state, game_reset); end
        @(negedge pxl_clk);
        checks++; if (game_state !== 3'd1 || lives_left !== 3'd3) begin errors++; $display("FAIL lost_reload got=%0d/%0d exp=1/3", game_state, lives_left); end
        send_tick();
        send_tick();
    endtask

    task automatic test_win_lose_same();
        @(negedge pxl_clk) begin win = 1'b1; lose = 1'b1; end
        @(negedge pxl_clk) win = 1'b0;
        checks++; if (game_state !== 3'd4 || lives_left !== 3'd3 || run !== 1'b0) begin errors++; $display("FAIL win_prio got=%0d/%0d/%b exp=4/3/0", game_state, lives_left, run); end
        send_tick();
        checks++; if (game_state !== 3'd4 || lives_left !== 3'd3) begin errors++; $display("FAIL won_ignore_lose got=%0d/%0d exp=4/3", game_state, lives_left); end
        lose = 1'b0;
        send_tick();
        send_tick();
        checks++; if (game_state !== 3'd6) begin errors++; $display("FAIL won_restart got=%0d exp=6", game_state); end
        @(negedge pxl_clk);
        send_tick();
        send_tick();
        checks++; if (game_state !== 3'd2) begin errors++; $display("FAIL won_replay got=%0d exp=2", game_state); end
    endtask

    task automatic test_abort_and_async();
        pulse_lose();
        @(negedge pxl_clk);
        send_tick();
        send_tick();
        @(negedge pxl_clk) start = 1'b0;
        @(negedge pxl_clk);
        checks++; if (game_state !== 3'd0 || run !== 1'b0 || lives_left !== 3'd2) begin errors++; $display("FAIL abort got=%0d/%b/%0d exp=0/0/2", game_state, run, lives_left); end
        start = 1'b1;
        repeat (2) @(negedge pxl_clk);
        checks++; if (game_state !== 3'd1 || lives_left !== 3'd3) begin errors++; $display("FAIL rearm got=%0d/%0d exp=1/3", game_state, lives_left); end
        lose = 1'b1;
        repeat (2) @(negedge pxl_clk);
        lose = 1'b0;
        checks++; if (game_state !== 3'd1 || lives_left !== 3'd3) begin errors++; $display("FAIL serve_ignore_lose got=%0d/%0d exp=1/3", game_state, lives_left); end
        send_tick();
        send_tick();
        pulse_lose();
        @(negedge pxl_clk);
        send_tick();
        // Mid-SERVE with lives=2 and frame count 1: reset with no clock edge.
        @(negedge pxl_clk);
        #5 reset = 1'b1;
        #1;
        checks++; if (game_state !== 3'd0 || run !== 1'b0 || lives_left !== 3'd3) begin errors++; $display("FAIL async_reset got=%0d/%b/%0d exp=0/0/3", game_state, run, lives_left); end
        @(negedge pxl_clk) reset = 1'b0;
        @(negedge pxl_clk);
        checks++; if (game_state !== 3'd6) begin errors++; $display("FAIL resume_idle got=%0d exp=6", game_state); end
    endtask

    initial begin
        test_reset();
        test_start_serve();
        test_miss();
        test_lives_out();
        test_win_lose_same();
        test_abort_and_async();
        repeat (2) @(negedge pxl_clk);
        checks++; if (br_max > 1) begin errors++; $display("FAIL ball_reset_width got=%0d exp<=1", br_max); end
        checks++; if (gr_max > 1) begin errors++; $display("FAIL game_reset_width got=%0d exp<=1", gr_max); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
